// File: rtl/fine_channelizer_pkg.sv
// Shared widths, helpers and types for the fine channelizer datapath.
package fine_channelizer_pkg;

   localparam int unsigned PROD_W = 32;
   localparam int unsigned OUT_W  = 16;
   localparam int unsigned SHIFT  = 15;
   localparam int unsigned N_TAPS = 8;

   function automatic int unsigned clog2_taps(input int unsigned n);
      return $clog2(n);
   endfunction

   localparam int unsigned ACC_W = PROD_W + clog2_taps(N_TAPS);

   typedef logic signed [ACC_W-1:0] acc_t;

endpackage

// File: rtl/fine_channelizer_round_sat.sv
// Combinational round-half-up, arithmetic shift and saturate to OUT_W bits.
module fine_channelizer_round_sat #(
   parameter int unsigned ACC_W = 35,
   parameter int unsigned OUT_W = 16,
   parameter int unsigned SHIFT = 15
) (
   input  logic signed [ACC_W-1:0] rnd,
   output logic signed [OUT_W-1:0] data,
   output logic                    sat
);

   // One guard bit so the rounding add cannot overflow.
   localparam int unsigned W = ACC_W + 1;
   localparam logic signed [W-1:0] HALF  = W'(1) << (SHIFT - 1);
   localparam logic signed [W-1:0] MAX_V = {{(W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
   localparam logic signed [W-1:0] MIN_V = {{(W - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};

   logic signed [W-1:0] biased;
   logic signed [W-1:0] shifted;

   always_comb begin
      biased  = {rnd[ACC_W-1], rnd} + HALF;
      shifted = biased >>> SHIFT;
      if (shifted > MAX_V) begin
         data = MAX_V[OUT_W-1:0];
         sat  = 1'b1;
      end else if (shifted < MIN_V) begin
         data = MIN_V[OUT_W-1:0];
         sat  = 1'b1;
      end else begin
         data = shifted[OUT_W-1:0];
         sat  = 1'b0;
      end
   end

endmodule

// File: rtl/fine_channelizer_tap_accum.sv
// Accumulates N_TAPS signed products per output, then rounds/saturates into a
// single-entry output register with valid/ready on both sides.
module fine_channelizer_tap_accum
   import fine_channelizer_pkg::*;
#(
   parameter int unsigned N_TAPS = fine_channelizer_pkg::N_TAPS,
   parameter int unsigned PROD_W = fine_channelizer_pkg::PROD_W,
   parameter int unsigned OUT_W  = fine_channelizer_pkg::OUT_W,
   parameter int unsigned SHIFT  = fine_channelizer_pkg::SHIFT
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     ce,
   input  logic                     prod_valid,
   output logic                     prod_ready,
   input  logic signed [PROD_W-1:0] prod,
   input  logic                     prod_last,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [OUT_W-1:0]  out_data,
   output logic                     out_sat,
   output logic                     tap_err
);

   localparam int unsigned ACC_W = PROD_W + clog2_taps(N_TAPS);
   localparam int unsigned CNT_W = clog2_taps(N_TAPS);

   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic signed [ACC_W-1:0] rnd_q, rnd_d;
   logic signed [ACC_W-1:0] sum;
   logic [CNT_W-1:0]        tap_cnt_q, tap_cnt_d;
   logic                    rnd_valid_q, rnd_valid_d;
   logic                    out_valid_q, out_valid_d;
   logic signed [OUT_W-1:0] out_data_q, out_data_d;
   logic                    out_sat_q, out_sat_d;
   logic                    tap_err_q, tap_err_d;
   logic signed [OUT_W-1:0] rs_data;
   logic                    rs_sat;
   logic                    acc_fire, out_fire, rnd_adv, at_end, close;

   fine_channelizer_round_sat #(
      .ACC_W (ACC_W),
      .OUT_W (OUT_W),
      .SHIFT (SHIFT)
   ) u_round_sat (
      .rnd  (rnd_q),
      .data (rs_data),
      .sat  (rs_sat)
   );

   always_comb begin
      // Stall only when a finished sum has nowhere to go.
      prod_ready = ce & ~(rnd_valid_q & out_valid_q & ~out_ready);
      acc_fire   = ce & prod_valid & prod_ready;
      out_fire   = ce & out_valid_q & out_ready;
      rnd_adv    = rnd_valid_q & ce & (~out_valid_q | out_ready);
      at_end     = (tap_cnt_q == CNT_W'(N_TAPS - 1));
      close      = acc_fire & (prod_last | at_end);
      sum        = acc_q + {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
   end

   always_comb begin
      acc_d       = acc_q;
      tap_cnt_d   = tap_cnt_q;
      rnd_d       = rnd_q;
      rnd_valid_d = rnd_valid_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_sat_d   = out_sat_q;
      tap_err_d   = tap_err_q;

      if (close) begin
         acc_d     = '0;
         tap_cnt_d = '0;
         rnd_d     = sum;
      end else if (acc_fire) begin
         acc_d     = sum;
         tap_cnt_d = tap_cnt_q + CNT_W'(1);
      end

      // A wrong-length frame: early last, or a full frame lacking its last flag.
      if (acc_fire && (prod_last != at_end)) begin
         tap_err_d = 1'b1;
      end

      if (close) begin
         rnd_valid_d = 1'b1;
      end else if (rnd_adv) begin
         rnd_valid_d = 1'b0;
      end

      if (rnd_adv) begin
         out_valid_d = 1'b1;
         out_data_d  = rs_data;
         out_sat_d   = rs_sat;
      end else if (out_fire) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q       <= '0;
         tap_cnt_q   <= '0;
         rnd_q       <= '0;
         rnd_valid_q <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sat_q   <= 1'b0;
         tap_err_q   <= 1'b0;
      end else begin
         acc_q       <= acc_d;
         tap_cnt_q   <= tap_cnt_d;
         rnd_q       <= rnd_d;
         rnd_valid_q <= rnd_valid_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_sat_q   <= out_sat_d;
         tap_err_q   <= tap_err_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_sat   = out_sat_q;
   assign tap_err   = tap_err_q;

endmodule
